// File: rtl/traffic_pkg.sv
// Shared types and defaults for the intersection controller's light-sensing path.
package traffic_pkg;
    typedef enum logic [1:0] {
        DAY        = 2'd0,
        DAY_PEND   = 2'd1,
        NIGHT      = 2'd2,
        NIGHT_PEND = 2'd3
    } night_state_t;

    localparam int LIGHT_W          = 10;
    localparam int NIGHT_ON_TH_DEF  = 800;
    localparam int NIGHT_OFF_TH_DEF = 760;
endpackage

// File: rtl/moving_avg_buf.sv
// Circular sample buffer with running sum; emits a truncated average one cycle
// after each sample once the buffer has filled.
module moving_avg_buf #(
    parameter int DATA_W   = 10,
    parameter int AVG_LOG2 = 3
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              clr,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample,
    output logic [DATA_W-1:0] avg_out,
    output logic              avg_valid
);
    localparam int SUM_W = DATA_W + AVG_LOG2;
    localparam int DEPTH = 1 << AVG_LOG2;
    localparam logic [AVG_LOG2:0] FULL = {1'b1, {AVG_LOG2{1'b0}}};

    logic [DATA_W-1:0]   mem [DEPTH];
    logic [AVG_LOG2-1:0] wr_ptr;
    logic [AVG_LOG2:0]   fill_cnt;
    logic [SUM_W-1:0]    sum;
    logic                upd;
    logic                full;
    logic [DATA_W-1:0]   old;

    assign full = (fill_cnt == FULL);
    assign old  = full ? mem[wr_ptr] : '0;

    // Contents are don't-care after clear: fill_cnt masks stale entries.
    always_ff @(posedge clk) begin
        if (sample_valid)
            mem[wr_ptr] <= sample;
    end

    always_ff @(posedge clk) begin
        if (!rstn || clr) begin
            wr_ptr    <= '0;
            fill_cnt  <= '0;
            sum       <= '0;
            upd       <= 1'b0;
            avg_out   <= '0;
            avg_valid <= 1'b0;
        end else begin
            // upd marks that sum holds a fully-warmed total for the next edge.
            upd       <= sample_valid && (full || fill_cnt == FULL - 1'b1);
            avg_valid <= upd;
            if (upd)
                avg_out <= sum[SUM_W-1:AVG_LOG2];
            if (sample_valid) begin
                wr_ptr <= wr_ptr + 1'b1;
                sum    <= sum + SUM_W'(sample) - SUM_W'(old);
                if (!full)
                    fill_cnt <= fill_cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/light_night_detector.sv
// Day/night decision from averaged light samples with hysteresis and dwell.
// Optional SENSOR_TIMEOUT_EN adds a no-sample watchdog that fails safe to DAY.
module light_night_detector
    import traffic_pkg::*;
#(
    parameter int DATA_W       = LIGHT_W,
    parameter int AVG_LOG2     = 3,
    parameter int NIGHT_ON_TH  = NIGHT_ON_TH_DEF,
    parameter int NIGHT_OFF_TH = NIGHT_OFF_TH_DEF,
    parameter int DWELL        = 10,
    parameter int TIMEOUT_CYC  = 100000000
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              enable,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample,
    output logic [DATA_W-1:0] avg_out,
    output logic              avg_valid,
    output logic              isnight,
    output logic              sensor_fault
);
    localparam int DW_W = (DWELL > 1) ? $clog2(DWELL + 1) : 1;
    localparam logic [DW_W-1:0]   DWELL_V = DW_W'(DWELL);
    localparam logic [DATA_W-1:0] ON_TH   = DATA_W'(NIGHT_ON_TH);
    localparam logic [DATA_W-1:0] OFF_TH  = DATA_W'(NIGHT_OFF_TH);

    night_state_t    state;
    logic [DW_W-1:0] dwell_cnt;
    logic            timeout_hit;

`ifdef SENSOR_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] to_cnt;

    assign timeout_hit = !sensor_fault && !sample_valid && (to_cnt == TO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (!rstn || !enable) begin
            to_cnt       <= '0;
            sensor_fault <= 1'b0;
        end else if (sample_valid) begin
            to_cnt       <= '0;
            sensor_fault <= 1'b0;
        end else if (!sensor_fault) begin
            to_cnt <= to_cnt + 1'b1;
            if (timeout_hit)
                sensor_fault <= 1'b1;
        end
    end
`else
    assign timeout_hit  = 1'b0;
    // Watchdog absent: the timeout parameter only matters in the other build.
    assign sensor_fault = (TIMEOUT_CYC < 0);
`endif

    moving_avg_buf #(.DATA_W(DATA_W), .AVG_LOG2(AVG_LOG2)) u_avg (
        .clk          (clk),
        .rstn         (rstn),
        .clr          (!enable || timeout_hit),
        .sample_valid (sample_valid),
        .sample       (sample),
        .avg_out      (avg_out),
        .avg_valid    (avg_valid)
    );

    always_ff @(posedge clk) begin
        if (!rstn || !enable || timeout_hit) begin
            state     <= DAY;
            dwell_cnt <= '0;
            isnight   <= 1'b0;
        end else if (avg_valid) begin
            case (state)
                DAY: if (avg_out >= ON_TH) begin
                    if (DWELL == 1) begin
                        state   <= NIGHT;
                        isnight <= 1'b1;
                    end else begin
                        state     <= DAY_PEND;
                        dwell_cnt <= DW_W'(1);
                    end
                end
                DAY_PEND: if (avg_out >= ON_TH) begin
                    if (dwell_cnt + DW_W'(1) == DWELL_V) begin
                        state     <= NIGHT;
                        isnight   <= 1'b1;
                        dwell_cnt <= '0;
                    end else begin
                        dwell_cnt <= dwell_cnt + DW_W'(1);
                    end
                end else begin
                    state     <= DAY;
                    dwell_cnt <= '0;
                end
                NIGHT: if (avg_out < OFF_TH) begin
                    if (DWELL == 1) begin
                        state   <= DAY;
                        isnight <= 1'b0;
                    end else begin
                        state     <= NIGHT_PEND;
                        dwell_cnt <= DW_W'(1);
                    end
                end
                NIGHT_PEND: if (avg_out < OFF_TH) begin
                    if (dwell_cnt + DW_W'(1) == DWELL_V) begin
                        state     <= DAY;
                        isnight   <= 1'b0;
                        dwell_cnt <= '0;
                    end else begin
                        dwell_cnt <= dwell_cnt + DW_W'(1);
                    end
                end else begin
                    state     <= NIGHT;
                    dwell_cnt <= '0;
                end
                default: state <= DAY;
            endcase
        end
    end
endmodule
